// File: rtl/fk_pkg.sv
// Shared constants, state encoding and select-width helper for the f(k) tap sequencer.
package fk_pkg;

  localparam int FK_W    = 25;
  localparam int FK_TAPS = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } fk_state_t;

  function automatic int tap_sel_w(input int taps);
    return $clog2(taps);
  endfunction

endpackage

// File: rtl/fk_history.sv
// Parametrised f(k) delay line with a zeroing random-access port and an
// unguarded port used by the sequencer to prefetch the next tap.
module fk_history import fk_pkg::*; #(
  parameter int W     = FK_W,
  parameter int TAPS  = FK_TAPS,
  parameter int SEL_W = tap_sel_w(TAPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic [W-1:0]     din,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     sel_out,
  input  logic [SEL_W-1:0] tap_sel,
  output logic [W-1:0]     tap_data
);

  logic [W-1:0] h [TAPS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) h[i] <= '0;
    end else if (shift) begin
      h[0] <= din;
      for (int i = 1; i < TAPS; i++) h[i] <= h[i-1];
    end
  end

  // Select codes past the last tap exist when TAPS is not a power of two.
  always_comb begin
    sel_out = '0;
    if (int'(sel) < TAPS) sel_out = h[sel];
  end

  assign tap_data = h[tap_sel];

endmodule

// File: rtl/fk_tap_sequencer.sv
// Streams the f(k) history one tap per cycle over valid/ready and keeps a
// combinational random-access read port for legacy datapath users.
module fk_tap_sequencer import fk_pkg::*; #(
  parameter int W     = FK_W,
  parameter int TAPS  = FK_TAPS,
  parameter int SEL_W = tap_sel_w(TAPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     sample_in,
  input  logic             sample_valid,
  input  logic             tap_ready,
  output logic [W-1:0]     tap_out,
  output logic [SEL_W-1:0] tap_idx,
  output logic             tap_valid,
  output logic             tap_last,
  output logic             busy,
  output logic             overrun,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     sel_out
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(TAPS - 1);

  fk_state_t        state;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] next_idx;
  logic [W-1:0]     tap_data;
  logic             final_hs;
  logic             accept;

  assign final_hs = tap_valid & tap_ready & tap_last;
  assign accept   = sample_valid & ((state == IDLE) | final_hs);
  assign next_idx = (idx == LAST) ? '0 : idx + 1'b1;
  assign tap_idx  = idx;

  fk_history #(
    .W     (W),
    .TAPS  (TAPS),
    .SEL_W (SEL_W)
  ) u_history (
    .clk      (clk),
    .reset    (reset),
    .shift    (accept),
    .din      (sample_in),
    .sel      (sel),
    .sel_out  (sel_out),
    .tap_sel  (next_idx),
    .tap_data (tap_data)
  );

  // tap_out is prefetched from the tap that becomes current after this edge;
  // wrapping next_idx to 0 leaves h[0] presented once the scan ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      tap_out   <= '0;
      tap_valid <= 1'b0;
      tap_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= sample_valid & ~accept;
      if (accept) begin
        state     <= SCAN;
        idx       <= '0;
        tap_out   <= sample_in;
        tap_valid <= 1'b1;
        tap_last  <= 1'b0;
        busy      <= 1'b1;
      end else if (state == SCAN && tap_ready) begin
        idx     <= next_idx;
        tap_out <= tap_data;
        if (idx == LAST) begin
          state     <= IDLE;
          tap_valid <= 1'b0;
          tap_last  <= 1'b0;
          busy      <= 1'b0;
        end else begin
          tap_last <= (next_idx == LAST);
        end
      end
    end
  end

endmodule
